mem_port_arb: RTL and testbench

Arbiter and sequencer that shares one single-ported synchronous memory between the instruction-fetch stage and the load/store stage of the MIPS core. It accepts one request at a time from each side, picks a winner, holds the memory port stable for the memory's fixed read latency, and returns data with a one-cycle acknowledge pulse. It sits between the fetch/PC logic, the data-memory access stage (driven by `DMWr`/load decode) and the unified memory macro.

---
 rtl/mem_port_arb_if.sv | 30 +++
 rtl/mem_port_arb.sv | 66 ++++++
 tb/tb_mem_port_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: fetch, load/store and memory-macro signals of the shared memory port.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one single-ported fixed-latency memory between fetch and load/store.
module mem_port_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rstn,
  mem_port_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state, state_n;
  logic              owner_if, we_q, grant_dm, grant_if, lat_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  logic [2:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  always_comb begin
    grant_dm = bus.dm_req && !(bus.if_req && starve_cnt == 4'(STARVE_MAX));
    grant_if = bus.if_req && !grant_dm;
    lat_done = lat_cnt == 3'(MEM_LAT);
    state_n  = state == IDLE   ? ((grant_dm || grant_if) ? ACCESS : IDLE) :
               state == ACCESS ? (lat_done ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        // only a data grant that bypasses a waiting fetch counts toward starvation
        starve_cnt <= (grant_dm && bus.if_req) ?
                      (starve_cnt == 4'(STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
        if (grant_dm || grant_if) begin
          owner_if <= grant_if;
          addr_q   <= grant_dm ? bus.dm_addr : bus.if_addr;
          wdata_q  <= grant_dm ? bus.dm_wdata : '0;
          we_q     <= grant_dm && bus.dm_we;
          lat_cnt  <= 3'd1;
        end
      end else if (state == ACCESS) begin
        if (!lat_done) lat_cnt <= lat_cnt + 3'd1;
        else if (owner_if) if_rdata_q <= bus.mem_rdata;
        else if (!we_q) dm_rdata_q <= bus.mem_rdata;
      end
    end
  end
  assign bus.mem_en    = state == ACCESS;
  assign bus.mem_we    = state == ACCESS && we_q && lat_cnt == 3'd1;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = state == RESP && owner_if;
  assign bus.dm_ack    = state == RESP && !owner_if;
  assign bus.busy      = state != IDLE;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed vectors, starvation/reset sequences and random traffic
// checked every cycle against a timestamp-based transaction model.
module tb_mem_port_arb;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  mem_port_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int i);
    return i == 16 ? 32'h2402000A : (i * 32'h00010001) ^ 32'hA5A50000;
  endfunction
  function automatic logic [31:0] rnd_addr();
    return {22'd0, 8'($urandom), 2'b00};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory macro: data is only valid in the cycle the read latency expires
  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  int acc_k;
  always @(posedge clk or negedge rstn)
    if (!rstn) acc_k <= 0;
    else acc_k <= bus.mem_en ? acc_k + 1 : 0;
  always @(posedge clk) if (bus.mem_we) mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
  assign bus.mem_rdata = (bus.mem_en && acc_k == LAT - 1) ? mem_arr[bus.mem_addr[9:2]] : 32'hBAD0BAD0;

  // transaction model: grant edge g, port busy until g+LAT+1, next arbitration at g+LAT+2
  int          cyc = 0, m_g = 0, m_starve = 0;
  bit          m_active = 0, m_if = 0, m_we = 0, dm_wins;
  logic [31:0] m_addr, m_wdata, m_data, m_if_data = 0, m_dm_data = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active = 0; m_starve = 0; m_if_data = 0; m_dm_data = 0;
    end else begin
      cyc++;
      if (m_active) begin
        if (cyc == m_g + LAT) begin
          if (m_if) m_if_data = m_data;
          else if (!m_we) m_dm_data = m_data;
        end
        if (cyc == m_g + LAT + 1) m_active = 0;
      end else begin
        dm_wins = bus.dm_req && !(bus.if_req && m_starve == SMAX);
        if (dm_wins || bus.if_req) begin
          m_active = 1; m_g = cyc; m_if = !dm_wins;
          m_we     = dm_wins && bus.dm_we;
          m_addr   = dm_wins ? bus.dm_addr : bus.if_addr;
          m_wdata  = dm_wins ? bus.dm_wdata : 32'd0;
          if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
          m_data = ref_mem[m_addr[9:2]];
        end
        m_starve = (dm_wins && bus.if_req) ? (m_starve < SMAX ? m_starve + 1 : m_starve) : 0;
      end
    end
  end

  int d;
  bit e_acc, e_we;
  always @(negedge clk) if (rstn) begin
    d     = cyc - m_g;
    e_acc = m_active && d < LAT;
    e_we  = m_active && d == 0 && m_we;
    chk("busy", bus.busy, m_active);
    chk("mem_en", bus.mem_en, e_acc);
    chk("mem_we", bus.mem_we, e_we);
    chk("if_ack", bus.if_ack, m_active && d == LAT && m_if);
    chk("dm_ack", bus.dm_ack, m_active && d == LAT && !m_if);
    chk("if_rdata", bus.if_rdata, m_if_data);
    chk("dm_rdata", bus.dm_rdata, m_dm_data);
    chk("starve_cnt", dut.starve_cnt, m_starve);
    if (e_acc) chk("mem_addr", bus.mem_addr, m_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
  end

  typedef struct {
    bit ir, dr, dw;
    logic [31:0] ia, da, wd;
    bit first_if;
    logic [31:0] e_if, e_dm;
  } vec_t;
  vec_t vt [6];

  initial begin
    int k, k_if, k_dm, we_n, n_dm, bad;
    bit got_if, got_dm;
    logic [31:0] r_if, r_dm;
    for (int i = 0; i < 256; i++) begin mem_arr[i] = mem_init(i); ref_mem[i] = mem_init(i); end
    vt[0] = '{1, 0, 0, 32'h40,  32'h0,   32'h0,        1, 32'h2402000A, 32'h0};
    vt[1] = '{0, 1, 1, 32'h0,   32'h100, 32'hDEADBEEF, 0, 32'h0,        32'h0};
    vt[2] = '{0, 1, 0, 32'h0,   32'h100, 32'h0,        0, 32'h0,        32'hDEADBEEF};
    vt[3] = '{1, 1, 0, 32'h80,  32'h200, 32'h0,        0, mem_init(32), mem_init(128)};
    vt[4] = '{1, 1, 1, 32'h100, 32'h200, 32'h12345678, 0, 32'hDEADBEEF, mem_init(128)};
    vt[5] = '{1, 0, 0, 32'h200, 32'h0,   32'h0,        1, 32'h12345678, 32'h0};
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    #2;
    chk("rst mem_en", bus.mem_en, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst acks", {bus.if_ack, bus.dm_ack}, 0);
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);

    foreach (vt[v]) begin
      bus.if_req = vt[v].ir; bus.if_addr = vt[v].ia;
      bus.dm_req = vt[v].dr; bus.dm_we = vt[v].dw; bus.dm_addr = vt[v].da; bus.dm_wdata = vt[v].wd;
      got_if = !vt[v].ir; got_dm = !vt[v].dr; k = 0; k_if = 0; k_dm = 0; we_n = 0; r_if = 0; r_dm = 0;
      while (!(got_if && got_dm) && k < 40) begin
        @(negedge clk);
        k++;
        if (bus.mem_we) we_n++;
        if (bus.if_ack && !got_if) begin got_if = 1; k_if = k; r_if = bus.if_rdata; bus.if_req = 0; end
        if (bus.dm_ack && !got_dm) begin got_dm = 1; k_dm = k; r_dm = bus.dm_rdata; bus.dm_req = 0; end
      end
      chk($sformatf("vec%0d acks_done", v), {got_if, got_dm}, 2'b11);
      if (vt[v].ir && vt[v].dr) begin
        chk($sformatf("vec%0d if_first", v), k_if < k_dm, vt[v].first_if);
        chk($sformatf("vec%0d first_lat", v), k_if < k_dm ? k_if : k_dm, LAT + 1);
        chk($sformatf("vec%0d second_lat", v), k_if < k_dm ? k_dm : k_if, 2 * LAT + 3);
      end else begin
        chk($sformatf("vec%0d ack_lat", v), vt[v].ir ? k_if : k_dm, LAT + 1);
      end
      if (vt[v].ir) chk($sformatf("vec%0d if_rdata", v), r_if, vt[v].e_if);
      if (vt[v].dr) chk($sformatf("vec%0d dm_rdata", v), r_dm, vt[v].e_dm);
      chk($sformatf("vec%0d we_pulses", v), we_n, vt[v].dr && vt[v].dw);
      repeat (2) @(negedge clk);
    end

    // starvation: data side re-requests after every ack while a fetch waits
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = rnd_addr();
    n_dm = 0; got_if = 0; k = 0;
    while (!got_if && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.dm_ack) begin n_dm++; bus.dm_addr = rnd_addr(); end
      if (bus.if_ack) begin got_if = 1; bus.if_req = 0; bus.dm_req = 0; end
    end
    chk("starve if_served", got_if, 1);
    chk("starve dm_grants", n_dm, SMAX);
    repeat (3) @(negedge clk);
    chk("starve cleared", dut.starve_cnt, 0);

    // reset in the second access cycle of a fetch
    bus.if_req = 1; bus.if_addr = 32'h80;
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 0;
    #1;
    chk("midrst mem_en", bus.mem_en, 0);
    chk("midrst mem_we", bus.mem_we, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst acks", {bus.if_ack, bus.dm_ack}, 0);
    chk("midrst if_rdata", bus.if_rdata, 0);
    chk("midrst dm_rdata", bus.dm_rdata, 0);
    chk("midrst mem_addr", bus.mem_addr, 0);
    bus.if_req = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_en || bus.if_ack || bus.dm_ack) bad++;
    end
    chk("post_rst idle activity", bad, 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.if_ack) begin bus.if_req = 1'($urandom); bus.if_addr = rnd_addr(); end
      else if (!bus.if_req && $urandom_range(2) == 0) begin bus.if_req = 1; bus.if_addr = rnd_addr(); end
      if (bus.dm_ack || (!bus.dm_req && $urandom_range(2) == 0)) begin
        bus.dm_req = bus.dm_ack ? 1'($urandom) : 1'b1;
        bus.dm_we = 1'($urandom); bus.dm_addr = rnd_addr(); bus.dm_wdata = $urandom;
      end
    end
    bus.if_req = 0; bus.dm_req = 0;
    repeat (LAT + 4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
